// File: rtl/mux4_rr_scheduler_pkg.sv
// Shared constants, state type and helpers for the four-way round-robin
// scheduler that drives a MUX4x1 select line.
package mux_sched_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_scheduler_if.sv
// Requester-side bundle: enable and request lines in, grant/select/busy out.
interface mux4_rr_scheduler_if;
  import mux_sched_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             busy;

  // Handshake: req[k] is held by requester k and means "route I[k]".
  // grant[k] with busy=1 means Y carries I[k] in that cycle; there is no ready.
  modport master (
    output en,
    output req,
    input  grant,
    input  sel,
    input  busy
  );

  modport slave (
    input  en,
    input  req,
    output grant,
    output sel,
    output busy
  );

endinterface

// File: rtl/mux4_rr_scheduler_rr_pick.sv
// Rotating priority encoder: the search begins just above 'last' and wraps,
// so 'last' itself has the lowest priority.
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] pos;

  // Walk from the lowest-priority offset to the highest, so the last hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      pos = last + SEL_W'(i);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner of a MUX4x1 channel: bounded bursts, rotation on release,
// back-to-back re-grant without an idle cycle.
module mux4_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mux4_rr_scheduler_if.slave    bus,
  output state_t                dbg_state
);

  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] pick_last;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             rel_cond;

  // While granted, sel_q is the current owner and becomes the new pointer on release.
  assign pick_last = (state_q == GRANT) ? sel_q : last_q;

  rr_pick u_pick (
    .req   (bus.req),
    .last  (pick_last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    rel_cond = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && pick_found) begin
          state_d = GRANT;
          grant_d = to_onehot(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = CNT_ONE;
        end
      end
      GRANT: begin
        rel_cond = !bus.req[sel_q] || (cnt_q == HOLD_CNT) || !bus.en;
        if (rel_cond) begin
          last_d = sel_q;
          if (bus.en && pick_found) begin
            grant_d = to_onehot(pick_idx);
            sel_d   = pick_idx;
            busy_d  = 1'b1;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Bench for mux4_rr_scheduler: HOLD_MAX=4 and HOLD_MAX=1 instances, a vector
// table, a hand-written HOLD_MAX=1 sequence and randomized traffic vs a model.
module tb_mux4_rr_scheduler;
  import mux_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux4_rr_scheduler_if if4 ();
  mux4_rr_scheduler_if if1 ();
  state_t dbg4, dbg1;

  mux4_rr_scheduler #(.HOLD_MAX(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave), .dbg_state(dbg4));
  mux4_rr_scheduler #(.HOLD_MAX(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .dbg_state(dbg1));

  // MUX4x1 data inputs I = 1010, Y = I[sel]
  logic [3:0] mux_i = 4'b1010;
  logic y4;
  assign y4 = mux_i[if4.sel];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner -1 means idle. Arbitration: first requester above the pointer, wrapping.
  int m_owner[2];
  int m_cnt[2];
  int m_last[2];
  int m_sel[2];
  int m_hold[2] = '{4, 1};

  function automatic int search(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic r, input logic e, input logic [3:0] q);
    int w;
    if (r) begin
      m_owner[d] = -1; m_cnt[d] = 0; m_last[d] = 3; m_sel[d] = 0;
    end else if (m_owner[d] < 0) begin
      if (e && q != 4'b0) begin
        w = search(q, m_last[d]);
        m_owner[d] = w; m_sel[d] = w; m_cnt[d] = 1;
      end
    end else if (!q[m_owner[d]] || m_cnt[d] == m_hold[d] || !e) begin
      m_last[d] = m_owner[d];
      if (e && q != 4'b0) begin
        w = search(q, m_owner[d]);
        m_owner[d] = w; m_sel[d] = w; m_cnt[d] = 1;
      end else begin
        m_owner[d] = -1;
      end
    end else begin
      m_cnt[d] = m_cnt[d] + 1;
    end
  endtask

  function automatic logic [6:0] model_out(input int d);
    logic [3:0] g;
    g = (m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]);
    return {g, 2'(m_sel[d]), (m_owner[d] >= 0)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q4[$];
  logic [6:0] exp_q1[$];

  task automatic check_dut(input string tag, input logic [6:0] exp,
                           input logic [3:0] g, input logic [1:0] s, input logic b,
                           input state_t st);
    check({tag, "_grant"}, 8'(g), 8'(exp[6:3]));
    check({tag, "_sel"},   8'(s), 8'(exp[2:1]));
    check({tag, "_busy"},  8'(b), 8'(exp[0]));
    check({tag, "_state"}, 8'(st == GRANT), 8'(exp[0]));
    check({tag, "_onehot0"}, 8'($onehot0(g)), 8'd1);
    check({tag, "_busy_or"}, 8'(b), 8'(|g));
    if (b) check({tag, "_sel_idx"}, 8'(g), 8'(4'b0001 << s));
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic r, input logic e, input logic [3:0] q);
    logic [6:0] e4, e1;
    rst = r; if4.en = e; if4.req = q; if1.en = e; if1.req = q;
    model_step(0, r, e, q);
    model_step(1, r, e, q);
    exp_q4.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
    @(posedge clk);
    #1;
    e4 = exp_q4.pop_front();
    e1 = exp_q1.pop_front();
    check_dut("h4", e4, if4.grant, if4.sel, if4.busy, dbg4);
    check_dut("h1", e1, if1.grant, if1.sel, if1.busy, dbg1);
    if (if4.busy) check("h4_y", 8'(y4), 8'(mux_i[e4[2:1]]));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] q;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [3:0] q,
                     input logic [3:0] g, input logic [1:0] s, input logic b);
    vec_t v;
    v.r = r; v.e = e; v.q = q; v.g = g; v.s = s; v.b = b;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] rq;
    logic       re, rr;
    rst = 1'b1; if4.en = 1'b0; if4.req = '0; if1.en = 1'b0; if1.req = '0;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_cnt[d] = 0; m_last[d] = 3; m_sel[d] = 0;
    end
    @(posedge clk); #1;

    // Reset values
    add(1, 0, 4'b0000, 4'b0000, 2'd0, 0);
    // Single requester: continuous across the 4-cycle boundary
    for (int i = 0; i < 6; i++) add(0, 1, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);
    // All requesting after reset: 4-cycle bursts rotating 0,1,2,3,0
    add(1, 1, 4'b0000, 4'b0000, 2'd0, 0);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 4; i++)
        add(0, 1, 4'b1111, 4'b0001 << (k % 4), 2'(k % 4), 1);
    add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);
    // 0110: owner 1 drops its request on the 2nd grant cycle
    add(0, 1, 4'b0110, 4'b0010, 2'd1, 1);
    add(0, 1, 4'b0110, 4'b0010, 2'd1, 1);
    add(0, 1, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 1, 4'b0100, 4'b0100, 2'd2, 1);
    // en low releases, sel holds; en back re-grants next cycle
    add(0, 0, 4'b0100, 4'b0000, 2'd2, 0);
    add(0, 1, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 1, 4'b0100, 4'b0100, 2'd2, 1);
    // Reset mid-grant, then requester 0 has top priority
    add(1, 1, 4'b0100, 4'b0000, 2'd0, 0);
    add(0, 1, 4'b1111, 4'b0001, 2'd0, 1);
    add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].q);
      check($sformatf("tbl%0d_grant", i), 8'(if4.grant), 8'(tbl[i].g));
      check($sformatf("tbl%0d_sel", i),   8'(if4.sel),   8'(tbl[i].s));
      check($sformatf("tbl%0d_busy", i),  8'(if4.busy),  8'(tbl[i].b));
    end

    // HOLD_MAX=1 with req=1010: alternates 0010 / 1000 every cycle
    tick(1, 1, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 4'b1010);
      check($sformatf("h1_alt%0d_grant", i), 8'(if1.grant),
            (i % 2 == 0) ? 8'h02 : 8'h08);
      check($sformatf("h1_alt%0d_sel", i), 8'(if1.sel),
            (i % 2 == 0) ? 8'h01 : 8'h03);
    end

    // Randomized traffic against the model
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      re = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      tick(rr, re, rq);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
